// File: rtl/rr_sel_gen_4_1.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_sel_gen_4_1 : round-robin 4-channel arbiter, mux select, 1-entry output reg
// Optional: RR_SEL_XFER_CNT_EN adds a 16-bit output handshake counter (xfer_cnt)
// Revision: 1.0
// ----------------------------------------------------------------------------
module rr_sel_gen_4_1 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   in_valid,
    output logic [3:0]   in_ready,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    output logic [1:0]   sel,
    output logic         out_valid,
    input  logic         out_ready,
`ifdef RR_SEL_XFER_CNT_EN
    output logic [15:0]  xfer_cnt,
`endif
    output logic [W-1:0] out_data
);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [1:0]   r_ptr;
    logic [W-1:0] r_data;

    logic         w_any;
    logic         w_load_en;
    logic         w_found;
    logic [1:0]   w_idx;
    logic [1:0]   w_grant;
    logic [W-1:0] w_data;

    assign w_any     = |in_valid;
    assign w_load_en = (r_state == S_EMPTY) | out_ready;

    // Scan channels starting at the pointer; the first requester wins.
    always_comb begin
        w_grant = r_ptr;
        w_found = 1'b0;
        w_idx   = r_ptr;
        for (int k = 0; k < 4; k++) begin
            w_idx = r_ptr + 2'(k);
            if (!w_found && in_valid[w_idx]) begin
                w_grant = w_idx;
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_data = d0;
        case (w_grant)
            2'd0:    w_data = d0;
            2'd1:    w_data = d1;
            2'd2:    w_data = d2;
            default: w_data = d3;
        endcase
    end

    always_comb begin
        in_ready = 4'b0000;
        if (!rst && w_load_en && w_any) begin
            in_ready = 4'b0001 << w_grant;
        end
    end

    assign sel = w_any ? w_grant : r_ptr;

    always_comb begin
        w_state_nxt = r_state;
        if (w_load_en) begin
            w_state_nxt = w_any ? S_FULL : S_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Data and pointer only move on an accepted grant; an idle drain leaves stale data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_ptr  <= 2'd0;
        end else if (w_load_en && w_any) begin
            r_data <= w_data;
            r_ptr  <= w_grant + 2'd1;
        end
    end

    assign out_valid = (r_state == S_FULL);
    assign out_data  = r_data;

`ifdef RR_SEL_XFER_CNT_EN
    logic [15:0] r_xfer_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_xfer_cnt <= 16'd0;
        end else if (out_valid && out_ready) begin
            r_xfer_cnt <= r_xfer_cnt + 16'd1;
        end
    end

    assign xfer_cnt = r_xfer_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rr_sel_gen_4_1.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_rr_sel_gen_4_1 : directed + random checks of rr_sel_gen_4_1 against a model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_rr_sel_gen_4_1;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [W-1:0] d0, d1, d2, d3;
    logic [1:0]   sel;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
`ifdef RR_SEL_XFER_CNT_EN
    logic [15:0]  xfer_cnt;
`endif

    int tests;
    int fails;

    // Reference state
    int           m_ptr;
    logic         m_ov;
    logic [W-1:0] m_od;
    int           m_cnt;

    rr_sel_gen_4_1 #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef RR_SEL_XFER_CNT_EN
        .xfer_cnt  (xfer_cnt),
`endif
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check against the model, advance the model at posedge.
    task automatic step(input logic r, input logic [3:0] iv, input logic ordy,
                        input logic [W-1:0] a0, input logic [W-1:0] a1,
                        input logic [W-1:0] a2, input logic [W-1:0] a3);
        logic [W-1:0] dv [4];
        int  g;
        bit  any;
        bit  load;
        logic [3:0] exp_rdy;
        @(negedge clk);
        rst = r; in_valid = iv; out_ready = ordy;
        d0 = a0; d1 = a1; d2 = a2; d3 = a3;
        dv[0] = a0; dv[1] = a1; dv[2] = a2; dv[3] = a3;
        #1;
        any = (iv != 4'b0000);
        g = m_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (iv[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
        end
        load = !m_ov || ordy;
        exp_rdy = (!r && load && any) ? (4'b0001 << g) : 4'b0000;
        chk("in_ready",  {28'd0, in_ready}, {28'd0, exp_rdy});
        chk("sel",       {30'd0, sel},      32'(g));
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
        chk("out_data",  32'(out_data),     32'(m_od));
`ifdef RR_SEL_XFER_CNT_EN
        chk("xfer_cnt",  {16'd0, xfer_cnt}, 32'(m_cnt));
`endif
        @(posedge clk);
        if (r) begin
            m_ov = 1'b0; m_od = '0; m_ptr = 0; m_cnt = 0;
        end else begin
            if (m_ov && ordy) m_cnt = (m_cnt + 1) % 65536;
            if (load) begin
                if (any) begin
                    m_od = dv[g]; m_ov = 1'b1; m_ptr = (g + 1) % 4;
                end else begin
                    m_ov = 1'b0;
                end
            end
        end
        #1;
    endtask

    initial begin
        tests = 0; fails = 0;
        m_ptr = 0; m_ov = 1'b0; m_od = '0; m_cnt = 0;
        rst = 1'b1; in_valid = 4'b0; out_ready = 1'b0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        @(posedge clk);
        #1;

        // Reset state
        step(1'b1, 4'b0000, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data",  32'(out_data),      32'd0);

        // All channels requesting: strict rotation 1,2,3,4,1
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'b1111, 1'b1, 4'h1, 4'h2, 4'h3, 4'h4);
            chk("rr_seq", 32'(out_data), 32'((i % 4) + 1));
        end

        // Idle drain: valid drops, pointer (now 1) drives sel
        step(1'b0, 4'b0000, 1'b1, 4'h1, 4'h2, 4'h3, 4'h4);
        chk("drain_valid", {31'd0, out_valid}, 32'd0);
        #1;
        chk("idle_sel", {30'd0, sel}, 32'd1);

        // Single channel 2, stalled three cycles
        step(1'b0, 4'b0100, 1'b0, 4'h0, 4'h0, 4'hA, 4'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'b0100, 1'b0, 4'h0, 4'h0, 4'hA, 4'h0);
            chk("stall_data", 32'(out_data), 32'hA);
        end
        step(1'b0, 4'b0000, 1'b1, 4'h0, 4'h0, 4'hA, 4'h0);
        #1;
        chk("ptr_after_ch2", {30'd0, sel}, 32'd3);

        // Channel 3 grant, then 1001 wraps to 0 before 3
        step(1'b0, 4'b1000, 1'b1, 4'h5, 4'h0, 4'h0, 4'h7);
        step(1'b0, 4'b1001, 1'b1, 4'h5, 4'h0, 4'h0, 4'h7);
        chk("wrap_ch0", 32'(out_data), 32'h5);
        step(1'b0, 4'b1001, 1'b1, 4'h5, 4'h0, 4'h0, 4'h7);
        chk("then_ch3", 32'(out_data), 32'h7);

        // Reset while full and stalled
        step(1'b0, 4'b0010, 1'b0, 4'h0, 4'h9, 4'h0, 4'h0);
        step(1'b1, 4'b0010, 1'b0, 4'h0, 4'h9, 4'h0, 4'h0);
        chk("rst_full_valid", {31'd0, out_valid}, 32'd0);
        step(1'b0, 4'b1111, 1'b1, 4'h1, 4'h2, 4'h3, 4'h4);
        chk("post_rst_ch0", 32'(out_data), 32'h1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 32) == 0, 4'($urandom), ($urandom % 4) != 0,
                 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
        end

`ifdef RR_SEL_XFER_CNT_EN
        step(1'b1, 4'b0000, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 4'b1111, 1'b1, 4'h1, 4'h2, 4'h3, 4'h4);
        end
        chk("cnt_5", {16'd0, xfer_cnt}, 32'd5);
        while (m_cnt != 16'hFFFF) begin
            step(1'b0, 4'b1111, 1'b1, 4'h1, 4'h2, 4'h3, 4'h4);
        end
        chk("cnt_ffff", {16'd0, xfer_cnt}, 32'hFFFF);
        step(1'b0, 4'b1111, 1'b1, 4'h1, 4'h2, 4'h3, 4'h4);
        chk("cnt_wrap", {16'd0, xfer_cnt}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
